// File: rtl/pwm_breathe_multi.sv
// Multi-channel LED breathing/PWM driver with per-channel mode select.
// A shared PWM period counter and a shared step prescaler drive CHANNELS
// duty engines; duty is double-buffered into act_duty at PWM period wrap.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         global run enable (0 = freeze state, outputs low)
//   mode       per channel, bits [2i+1:2i]: 00 off, 01 on, 10 breathe, 11 blink
//   led_out    registered PWM outputs
//   step_tick  one-cycle pulse following each duty step strobe
//
// Optional feature macro: PWM_PHASE_STAGGER_EN
//   defined   -> channel i resets to DUTY_MIN + i*((DUTY_MAX-DUTY_MIN)/CHANNELS)
//   undefined -> every channel resets to DUTY_MIN (lockstep breathing)
module pwm_breathe_multi #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned PWM_PERIOD = 100,
    parameter int unsigned STEP_TICKS = 5000000,
    parameter int unsigned DUTY_MIN   = 1,
    parameter int unsigned DUTY_MAX   = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [2*CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0]   led_out,
    output logic                  step_tick
);

    localparam int unsigned PW = $clog2(PWM_PERIOD) + 1;
    localparam int unsigned SW = $clog2(STEP_TICKS) + 1;

    localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_TICKS - 1);
    localparam logic [PW-1:0] D_MIN     = PW'(DUTY_MIN);
    localparam logic [PW-1:0] D_MAX     = PW'(DUTY_MAX);

`ifdef PWM_PHASE_STAGGER_EN
    localparam int unsigned STAGGER = (DUTY_MAX - DUTY_MIN) / CHANNELS;
`else
    localparam int unsigned STAGGER = 0;
`endif

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_ON      = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_BLINK   = 2'b11;

    logic [PW-1:0] pwm_cnt;
    logic [SW-1:0] step_cnt;
    logic [PW-1:0] duty     [CHANNELS];
    logic [PW-1:0] act_duty [CHANNELS];
    logic          dir_up   [CHANNELS];
    logic          blink    [CHANNELS];

    logic wrap_c;
    logic strobe_c;

    // Period wrap and step strobe only fire while running.
    assign wrap_c   = en && (pwm_cnt == PWM_LAST);
    assign strobe_c = en && (step_cnt == STEP_LAST);

    // Shared counters, per-channel duty engines and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt   <= '0;
            step_cnt  <= '0;
            step_tick <= 1'b0;
            led_out   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty[i]     <= PW'(DUTY_MIN + i * STAGGER);
                act_duty[i] <= PW'(DUTY_MIN + i * STAGGER);
                dir_up[i]   <= 1'b1;
                blink[i]    <= 1'b0;
            end
        end else begin
            step_tick <= strobe_c;

            if (en) begin
                pwm_cnt  <= wrap_c   ? '0 : pwm_cnt + PW'(1);
                step_cnt <= strobe_c ? '0 : step_cnt + SW'(1);
            end

            for (int i = 0; i < CHANNELS; i++) begin
                // Shadow load sees duty before this cycle's step update.
                if (wrap_c) begin
                    act_duty[i] <= duty[i];
                end

                // Triangle sweep with direction reversal and no dwell at the ends.
                if (strobe_c && mode[2*i +: 2] == MODE_BREATHE) begin
                    if (dir_up[i]) begin
                        if (duty[i] < D_MAX) begin
                            duty[i] <= duty[i] + PW'(1);
                        end else begin
                            dir_up[i] <= 1'b0;
                            duty[i]   <= duty[i] - PW'(1);
                        end
                    end else begin
                        if (duty[i] > D_MIN) begin
                            duty[i] <= duty[i] - PW'(1);
                        end else begin
                            dir_up[i] <= 1'b1;
                            duty[i]   <= duty[i] + PW'(1);
                        end
                    end
                end

                if (strobe_c && mode[2*i +: 2] == MODE_BLINK) begin
                    blink[i] <= ~blink[i];
                end

                // Mode is applied directly, not deferred to the period boundary.
                if (!en) begin
                    led_out[i] <= 1'b0;
                end else begin
                    case (mode[2*i +: 2])
                        MODE_OFF:     led_out[i] <= 1'b0;
                        MODE_ON:      led_out[i] <= 1'b1;
                        MODE_BREATHE: led_out[i] <= (pwm_cnt < act_duty[i]);
                        default:      led_out[i] <= blink[i] && (pwm_cnt < D_MAX);
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// Self-checking bench for pwm_breathe_multi (CHANNELS=2, PWM_PERIOD=10,
// STEP_TICKS=20, DUTY_MIN=1, DUTY_MAX=4). The reference model counts enabled
// cycles and breathe steps per channel and derives duty from a closed-form
// triangle wave; outputs are compared on every falling edge.
module tb_pwm_breathe_multi;

    localparam int unsigned CH   = 2;
    localparam int unsigned P    = 10;
    localparam int unsigned S    = 20;
    localparam int unsigned DMIN = 1;
    localparam int unsigned DMAX = 4;
    localparam int unsigned R    = DMAX - DMIN;
    localparam int unsigned L    = 2 * R;
`ifdef PWM_PHASE_STAGGER_EN
    localparam int unsigned STG  = R / CH;
`else
    localparam int unsigned STG  = 0;
`endif

    logic            clk  = 1'b0;
    logic            rst  = 1'b1;
    logic            en   = 1'b0;
    logic [2*CH-1:0] mode = '0;
    logic [CH-1:0]   led_out;
    logic            step_tick;

    pwm_breathe_multi #(
        .CHANNELS   (CH),
        .PWM_PERIOD (P),
        .STEP_TICKS (S),
        .DUTY_MIN   (DMIN),
        .DUTY_MAX   (DMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .led_out   (led_out),
        .step_tick (step_tick)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, want);
        end
    endtask

    // Reference model state
    int unsigned   t;           // enabled cycles since reset
    int unsigned   k   [CH];    // breathe steps taken per channel
    int unsigned   act [CH];    // duty latched at last period wrap
    bit            blk [CH];
    logic [CH-1:0] exp_led;
    logic          exp_tick;

    // Triangle wave starting at init duty heading up, period L steps.
    function automatic int unsigned tri_duty(input int unsigned ch, input int unsigned steps);
        int unsigned p;
        p = (ch * STG + steps) % L;
        return (p <= R) ? DMIN + p : DMIN + L - p;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t        = 0;
            exp_led  = '0;
            exp_tick = 1'b0;
            for (int c = 0; c < CH; c++) begin
                k[c]   = 0;
                act[c] = tri_duty(c, 0);
                blk[c] = 1'b0;
            end
        end else begin
            exp_tick = en && (t % S == S - 1);
            for (int c = 0; c < CH; c++) begin
                case (mode[2*c +: 2])
                    2'b00:   exp_led[c] = 1'b0;
                    2'b01:   exp_led[c] = 1'b1;
                    2'b10:   exp_led[c] = (t % P) < act[c];
                    default: exp_led[c] = blk[c] && ((t % P) < DMAX);
                endcase
                if (!en) exp_led[c] = 1'b0;
                if (en) begin
                    if (t % P == P - 1) act[c] = tri_duty(c, k[c]);
                    if (t % S == S - 1) begin
                        if (mode[2*c +: 2] == 2'b10) k[c]++;
                        if (mode[2*c +: 2] == 2'b11) blk[c] = ~blk[c];
                    end
                end
            end
            if (en) t++;
        end
    end

    always @(negedge clk) begin
        chk("led_out", 32'(led_out), rst ? 32'd0 : 32'(exp_led));
        chk("step_tick", 32'(step_tick), rst ? 32'd0 : 32'(exp_tick));
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int cnt;
        run(3);
        rst  = 1'b0;
        mode = 4'b1010;
        en   = 1'b1;

        // One lit cycle per period at the reset duty of channel 0.
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            cnt += int'(led_out[0]);
        end
        chk("hi_per_period", 32'(cnt), 32'(DMIN));
        run(250);

        // Mode switching on channel 0.
        mode[1:0] = 2'b01;
        run(33);
        mode[1:0] = 2'b00;
        run(27);
        mode[1:0] = 2'b10;
        run(120);

        // Blink on both channels.
        mode = 4'b1111;
        run(120);

        // Freeze for 37 cycles mid-sweep.
        mode = 4'b1010;
        run(73);
        en = 1'b0;
        run(37);
        en = 1'b1;
        run(200);

        // Asynchronous reset between clock edges while running.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_led", 32'(led_out), 32'd0);
        chk("async_rst_tick", 32'(step_tick), 32'd0);
        run(2);
        rst = 1'b0;
        run(60);

        // Randomized mode and enable traffic.
        repeat (3000) begin
            run(1);
            if ($urandom_range(0, 29) == 0) mode = 4'($urandom);
            if ($urandom_range(0, 49) == 0) en = ~en;
        end
        en = 1'b1;
        run(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
